// File: rtl/fejkon_pcie_pkg.sv
// Shared types and constants for the fejkon PCIe BAR0 request path.
package fejkon_pcie_pkg;

  localparam int PCIE_TAG_W  = 5;
  localparam int BAR0_ADDR_W = 12;

  typedef struct packed {
    logic                   write;
    logic [BAR0_ADDR_W-1:0] addr;
    logic [31:0]            data;
    logic [PCIE_TAG_W-1:0]  tag;
  } bar_req_t;

  typedef struct packed {
    logic [PCIE_TAG_W-1:0] tag;
    logic [31:0]           data;
  } bar_cpl_t;

  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return |addr_lsb;
  endfunction

endpackage

// File: rtl/fejkon_sync_fifo.sv
// Single-clock show-ahead FIFO with full/empty flags and an occupancy count.
module fejkon_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 32
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: storage has no reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/fejkon_pcie_bar_sched.sv
// In-order BAR0 request scheduler: pipelined Avalon reads, credit backpressure, UR on misalignment.
// Optional duplicate-tag detection when FEJKON_PCIE_TAG_CHECK_EN is defined.
module fejkon_pcie_bar_sched
  import fejkon_pcie_pkg::*;
#(
  parameter int ADDR_W      = BAR0_ADDR_W,
  parameter int MAX_PENDING = 32,
  parameter int TAG_W       = PCIE_TAG_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_data,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid,
  output logic              cpl_valid,
  input  logic              cpl_ready,
  output logic [TAG_W-1:0]  cpl_tag,
  output logic [31:0]       cpl_data,
  output logic              cpl_err_ur_p,
  output logic              cpl_err_ur_np,
  output logic [5:0]        pending
);

  localparam int         CNT_W    = $clog2(MAX_PENDING) + 1;
  localparam logic [6:0] PEND_MAX = 7'(MAX_PENDING);

  bar_req_t           slot_q;
  logic               slot_valid;
  logic               misaligned, is_dup, req_fire, load_slot;
  logic               tag_push, tag_pop, tag_full, tag_empty;
  logic [TAG_W-1:0]   tag_head;
  logic [CNT_W-1:0]   tag_count, cpl_count;
  logic               cpl_pop, cpl_full, cpl_empty;
  bar_cpl_t           cpl_in, cpl_head;
  logic [6:0]         pend_sum;
  logic               rdv_block;

  assign misaligned = is_misaligned(req_addr[1:0]);
  assign req_ready  = reset_n && (!slot_valid || !avm_waitrequest)
                      && (req_write || (pend_sum < PEND_MAX));
  assign req_fire   = req_valid && req_ready;
  assign load_slot  = req_fire && !misaligned && !is_dup;

`ifdef FEJKON_PCIE_TAG_CHECK_EN
  logic [2**TAG_W-1:0] tag_busy;
  logic                tag_set;

  // A tag retired by this cycle's completion pop may be reused immediately.
  assign is_dup  = !req_write && !misaligned && tag_busy[req_tag]
                   && !(cpl_pop && (cpl_head.tag == req_tag));
  assign tag_set = req_fire && !req_write && !misaligned && !is_dup;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_busy <= '0;
    end else begin
      if (cpl_pop) tag_busy[cpl_head.tag] <= 1'b0;
      if (tag_set) tag_busy[req_tag] <= 1'b1;
    end
  end
`else
  assign is_dup = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      slot_valid    <= 1'b0;
      slot_q        <= '0;
      cpl_err_ur_p  <= 1'b0;
      cpl_err_ur_np <= 1'b0;
      rdv_block     <= 1'b1;
    end else begin
      if (load_slot) begin
        slot_valid <= 1'b1;
        slot_q     <= '{write: req_write, addr: req_addr, data: req_data, tag: req_tag};
      end else if (slot_valid && !avm_waitrequest) begin
        slot_valid <= 1'b0;
      end
      cpl_err_ur_p  <= req_fire && req_write && misaligned;
      cpl_err_ur_np <= req_fire && !req_write && (misaligned || is_dup);
      // Read data still in flight from before reset is dropped until new traffic starts.
      if (req_fire) rdv_block <= 1'b0;
    end
  end

  assign avm_read      = slot_valid && !slot_q.write;
  assign avm_write     = slot_valid && slot_q.write;
  assign avm_address   = slot_q.addr;
  assign avm_writedata = slot_q.data;

  assign tag_push = avm_read && !avm_waitrequest && !tag_full;
  assign tag_pop  = avm_readdatavalid && !rdv_block && !tag_empty && !cpl_full;
  assign cpl_in   = '{tag: tag_head, data: avm_readdata};

  fejkon_sync_fifo #(.WIDTH(TAG_W), .DEPTH(MAX_PENDING)) u_tag_fifo (
    .clk(clk), .reset_n(reset_n),
    .push(tag_push), .wdata(slot_q.tag),
    .pop(tag_pop), .rdata(tag_head),
    .full(tag_full), .empty(tag_empty), .count(tag_count)
  );

  fejkon_sync_fifo #(.WIDTH($bits(bar_cpl_t)), .DEPTH(MAX_PENDING)) u_cpl_fifo (
    .clk(clk), .reset_n(reset_n),
    .push(tag_pop), .wdata(cpl_in),
    .pop(cpl_pop), .rdata(cpl_head),
    .full(cpl_full), .empty(cpl_empty), .count(cpl_count)
  );

  assign cpl_valid = !cpl_empty;
  assign cpl_pop   = cpl_valid && cpl_ready;
  assign cpl_tag   = cpl_valid ? cpl_head.tag : '0;
  assign cpl_data  = cpl_valid ? cpl_head.data : '0;

  // Reads held in the slot, awaiting data, or buffered as completions.
  assign pend_sum = 7'(avm_read) + 7'(tag_count) + 7'(cpl_count);

  always_comb begin
    // NOTE: default first so every path assigns pending and no latch is inferred.
    pending = pend_sum[5:0];
    if (pend_sum > PEND_MAX) pending = PEND_MAX[5:0];
  end

  assert property (@(posedge clk) disable iff (!reset_n)
                   !(avm_readdatavalid && !rdv_block && tag_empty))
    else $fatal(1, "avm_readdatavalid with no outstanding read tag");

endmodule

// File: tb/tb_fejkon_pcie_bar_sched.sv
// Directed self-checking bench for fejkon_pcie_bar_sched with a 3-cycle Avalon memory model.
module tb_fejkon_pcie_bar_sched;

  localparam int LAT = 3;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
  logic [11:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic [4:0]  req_tag = '0;
  logic [11:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic        wait_req = 1'b0;
  logic [31:0] rdata = '0;
  logic        rdv = 1'b0;
  logic        cpl_valid, cpl_ready = 1'b0;
  logic [4:0]  cpl_tag;
  logic [31:0] cpl_data;
  logic        cpl_err_ur_p, cpl_err_ur_np;
  logic [5:0]  pending;

  int vectors = 0;
  int miscompares = 0;

  fejkon_pcie_bar_sched dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_data(req_data), .req_tag(req_tag),
    .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
    .avm_writedata(avm_writedata), .avm_waitrequest(wait_req),
    .avm_readdata(rdata), .avm_readdatavalid(rdv),
    .cpl_valid(cpl_valid), .cpl_ready(cpl_ready), .cpl_tag(cpl_tag), .cpl_data(cpl_data),
    .cpl_err_ur_p(cpl_err_ur_p), .cpl_err_ur_np(cpl_err_ur_np), .pending(pending)
  );

  always #5 clk = ~clk;

  // Bus memory model and observers, all sampled on the falling edge.
  logic [31:0] mem [1024];
  logic [11:0] rsp_addr [$];
  int          rsp_due [$];
  logic [4:0]  log_tag [$];
  logic [31:0] log_data [$];
  int ncyc = 0, wr_cnt = 0, rd_cnt = 0, urp_cnt = 0, urnp_cnt = 0;

  always @(negedge clk) begin
    ncyc++;
    rdv = 1'b0;
    if (rsp_due.size() > 0 && rsp_due[0] == ncyc) begin
      rdv   = 1'b1;
      rdata = mem[rsp_addr[0][11:2]];
      void'(rsp_addr.pop_front());
      void'(rsp_due.pop_front());
    end
    if (avm_write && !wait_req) begin
      wr_cnt++;
      mem[avm_address[11:2]] = avm_writedata;
    end
    if (avm_read && !wait_req) begin
      rd_cnt++;
      rsp_addr.push_back(avm_address);
      rsp_due.push_back(ncyc + LAT);
    end
    if (cpl_valid && cpl_ready) begin
      log_tag.push_back(cpl_tag);
      log_data.push_back(cpl_data);
    end
    if (cpl_err_ur_p)  urp_cnt++;
    if (cpl_err_ur_np) urnp_cnt++;
  end

  function automatic logic [92:0] all_outs();
    return {req_ready, avm_read, avm_write, avm_address, avm_writedata, cpl_valid,
            cpl_tag, cpl_data, cpl_err_ur_p, cpl_err_ur_np, pending};
  endfunction

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send_req(input logic w, input logic [11:0] a, input logic [31:0] d,
                          input logic [4:0] t, output bit ok);
    req_valid = 1'b1; req_write = w; req_addr = a; req_data = d; req_tag = t;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        @(posedge clk); #1;
        break;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic wait_log(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (log_tag.size() >= n) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    #1;
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++; $display("FAIL reset_outputs: got %h, want 0", all_outs());
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (req_ready !== 1'b1 || pending !== 6'd0) begin
      miscompares++; $display("FAIL reset_release: req_ready=%b pending=%0d, want 1/0", req_ready, pending);
    end
  endtask

  task automatic test_misaligned();
    int w0 = wr_cnt, r0 = rd_cnt, p0 = urp_cnt, n0 = urnp_cnt, l0 = log_tag.size();
    bit ok;
    send_req(1'b1, 12'd14, 32'h1337, 5'd0, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL misalign_wr_accept: ready=0, want 1"); end
    @(negedge clk);
    vectors++;
    if (cpl_err_ur_p !== 1'b1 || cpl_err_ur_np !== 1'b0) begin
      miscompares++; $display("FAIL misalign_wr_pulse: ur_p=%b ur_np=%b, want 1/0", cpl_err_ur_p, cpl_err_ur_np);
    end
    @(negedge clk);
    vectors++;
    if (cpl_err_ur_p !== 1'b0) begin miscompares++; $display("FAIL misalign_wr_width: ur_p=%b, want 0", cpl_err_ur_p); end
    repeat (3) @(negedge clk);
    vectors++;
    if (wr_cnt != w0 || urp_cnt - p0 != 1 || urnp_cnt != n0) begin
      miscompares++; $display("FAIL misalign_wr_counts: writes=%0d urp=%0d urnp=%0d, want 0/1/0",
                              wr_cnt - w0, urp_cnt - p0, urnp_cnt - n0);
    end
    @(posedge clk); #1;
    send_req(1'b0, 12'd14, 32'h0, 5'd5, ok);
    @(negedge clk);
    vectors++;
    if (cpl_err_ur_np !== 1'b1 || cpl_err_ur_p !== 1'b0) begin
      miscompares++; $display("FAIL misalign_rd_pulse: ur_np=%b ur_p=%b, want 1/0", cpl_err_ur_np, cpl_err_ur_p);
    end
    @(negedge clk);
    vectors++;
    if (cpl_err_ur_np !== 1'b0) begin miscompares++; $display("FAIL misalign_rd_width: ur_np=%b, want 0", cpl_err_ur_np); end
    repeat (5) @(negedge clk);
    vectors++;
    if (rd_cnt != r0 || log_tag.size() != l0 || pending !== 6'd0 || urnp_cnt - n0 != 1) begin
      miscompares++; $display("FAIL misalign_rd_counts: reads=%0d cpls=%0d pending=%0d urnp=%0d, want 0/0/0/1",
                              rd_cnt - r0, log_tag.size() - l0, pending, urnp_cnt - n0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    int w0 = wr_cnt, l0 = log_tag.size(), bad = 0;
    bit ok;
    cpl_ready = 1'b1;
    for (int i = 0; i < 31; i++) begin
      send_req(1'b1, 12'(i * 4), 32'(i * 4), 5'd0, ok);
      if (!ok) bad++;
    end
    for (int i = 0; i < 31; i++) begin
      send_req(1'b0, 12'(i * 4), 32'h0, 5'(i), ok);
      if (!ok) bad++;
    end
    vectors++;
    if (bad != 0) begin miscompares++; $display("FAIL stream_accept: %0d stalled, want 0", bad); end
    wait_log(l0 + 31, ok);
    vectors++;
    if (!ok) begin miscompares++; $display("FAIL stream_cpl_count: got %0d, want 31", log_tag.size() - l0); end
    for (int i = 0; i < 31; i++) begin
      vectors++;
      if (log_tag[l0 + i] !== 5'(i) || log_data[l0 + i] !== 32'(i * 4)) begin
        miscompares++; $display("FAIL stream_cpl[%0d]: tag=%0d data=%h, want %0d/%h",
                                i, log_tag[l0 + i], log_data[l0 + i], i, 32'(i * 4));
      end
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (pending !== 6'd0 || wr_cnt - w0 != 31) begin
      miscompares++; $display("FAIL stream_end: pending=%0d writes=%0d, want 0/31", pending, wr_cnt - w0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_credit();
    int l0 = log_tag.size(), acc = 0, early = 0;
    bit ok;
    cpl_ready = 1'b0;
    req_write = 1'b0; req_addr = 12'd0; req_data = 32'h0;
    for (int i = 0; i < 32; i++) begin
      req_valid = 1'b1; req_tag = 5'(i);
      @(negedge clk);
      if (req_ready) acc++;
      @(posedge clk); #1;
    end
    req_tag = 5'd0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (req_ready) early++;
    end
    vectors++;
    if (acc != 32 || early != 0) begin
      miscompares++; $display("FAIL credit_accept: accepted=%0d ready_on_33rd=%0d, want 32/0", acc, early);
    end
    vectors++;
    if (pending !== 6'd32 || cpl_valid !== 1'b1 || log_tag.size() != l0) begin
      miscompares++; $display("FAIL credit_full: pending=%0d cpl_valid=%b, want 32/1", pending, cpl_valid);
    end
    @(posedge clk); #1;
    cpl_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b0) begin miscompares++; $display("FAIL credit_pop_cycle: ready=%b, want 0", req_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1) begin miscompares++; $display("FAIL credit_after_pop: ready=%b, want 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_log(l0 + 33, ok);
    vectors++;
    if (!ok || log_tag[l0 + 31] !== 5'd31 || log_tag[l0 + 32] !== 5'd0) begin
      miscompares++; $display("FAIL credit_drain: cpls=%0d tag31=%0d tag32=%0d, want 33/31/0",
                              log_tag.size() - l0, log_tag[l0 + 31], log_tag[l0 + 32]);
    end
    repeat (3) @(negedge clk);
    vectors++;
    if (pending !== 6'd0 || log_tag.size() != l0 + 33) begin
      miscompares++; $display("FAIL credit_end: pending=%0d cpls=%0d, want 0/33", pending, log_tag.size() - l0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_waitrequest();
    int w0 = wr_cnt, l0;
    bit ok;
    cpl_ready = 1'b1;
    wait_req  = 1'b1;
    send_req(1'b1, 12'd512, 32'hdeadbeef, 5'd0, ok);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      vectors++;
      if (avm_write !== 1'b1 || avm_address !== 12'd512 || avm_writedata !== 32'hdeadbeef) begin
        miscompares++; $display("FAIL wait_hold[%0d]: wr=%b addr=%0d data=%h, want 1/512/deadbeef",
                                k, avm_write, avm_address, avm_writedata);
      end
    end
    @(posedge clk); #1;
    wait_req = 1'b0;
    l0 = log_tag.size();
    send_req(1'b0, 12'd512, 32'h0, 5'd9, ok);
    wait_log(l0 + 1, ok);
    vectors++;
    if (!ok || log_tag[l0] !== 5'd9 || log_data[l0] !== 32'hdeadbeef) begin
      miscompares++; $display("FAIL wait_readback: tag=%0d data=%h, want 9/deadbeef", log_tag[l0], log_data[l0]);
    end
    vectors++;
    if (wr_cnt - w0 != 1) begin miscompares++; $display("FAIL wait_commits: writes=%0d, want 1", wr_cnt - w0); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    int l0, stray = 0;
    bit ok;
    cpl_ready = 1'b0;
    for (int i = 1; i <= 4; i++) send_req(1'b0, 12'd512, 32'h0, 5'(i), ok);
    reset_n = 1'b0;
    #1;
    vectors++;
    if (all_outs() !== '0) begin miscompares++; $display("FAIL midreset_outputs: got %h, want 0", all_outs()); end
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cpl_ready = 1'b1;
    l0 = log_tag.size();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (cpl_valid) stray++;
    end
    vectors++;
    if (stray != 0 || log_tag.size() != l0 || pending !== 6'd0) begin
      miscompares++; $display("FAIL midreset_stale: cpl_valid_cycles=%0d pending=%0d, want 0/0", stray, pending);
    end
    @(posedge clk); #1;
    send_req(1'b0, 12'd512, 32'h0, 5'd7, ok);
    wait_log(l0 + 1, ok);
    vectors++;
    if (!ok || log_tag[l0] !== 5'd7 || log_data[l0] !== 32'hdeadbeef) begin
      miscompares++; $display("FAIL midreset_recover: tag=%0d data=%h, want 7/deadbeef", log_tag[l0], log_data[l0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_dup_tag();
    int n0 = urnp_cnt, l0 = log_tag.size(), exp_cpl, exp_ur;
    bit ok;
`ifdef FEJKON_PCIE_TAG_CHECK_EN
    exp_cpl = 1; exp_ur = 1;
`else
    exp_cpl = 2; exp_ur = 0;
`endif
    cpl_ready = 1'b0;
    send_req(1'b0, 12'd512, 32'h0, 5'd3, ok);
    send_req(1'b0, 12'd512, 32'h0, 5'd3, ok);
    repeat (6) @(negedge clk);
    vectors++;
    if (urnp_cnt - n0 != exp_ur || pending !== 6'(exp_cpl)) begin
      miscompares++; $display("FAIL dup_state: ur_np=%0d pending=%0d, want %0d/%0d",
                              urnp_cnt - n0, pending, exp_ur, exp_cpl);
    end
    @(posedge clk); #1;
    cpl_ready = 1'b1;
    wait_log(l0 + exp_cpl, ok);
    repeat (4) @(negedge clk);
    vectors++;
    if (!ok || log_tag.size() != l0 + exp_cpl) begin
      miscompares++; $display("FAIL dup_count: cpls=%0d, want %0d", log_tag.size() - l0, exp_cpl);
    end
    for (int i = 0; i < exp_cpl; i++) begin
      vectors++;
      if (log_tag[l0 + i] !== 5'd3 || log_data[l0 + i] !== 32'hdeadbeef) begin
        miscompares++; $display("FAIL dup_cpl[%0d]: tag=%0d data=%h, want 3/deadbeef", i, log_tag[l0 + i], log_data[l0 + i]);
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #2 reset_n = 1'b0;
    test_reset();
    test_misaligned();
    test_stream();
    test_credit();
    test_waitrequest();
    test_reset_mid();
    test_dup_tag();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fejkon_pcie_bar_sched.md
Name: fejkon_pcie_bar_sched

Overview:
Scheduler between the PCIe HIP BAR0 request decoder and the BAR0 Avalon-MM register bus. It accepts single-dword memory read/write requests in arrival order and issues them to the bus with pipelined reads. It tracks up to 32 outstanding read tags and returns completions in order. It replaces drop-on-full with explicit backpressure and raises the unsupported-request (UR) error strobes for misaligned accesses.

Parameters:
ADDR_W, 12, BAR0 byte-address width
MAX_PENDING, 32, max reads in flight plus buffered completions (power of 2, ≤32)
TAG_W, 5, PCIe tag width

Ports:
clk  in  1  single clock domain
reset_n  in  1  asynchronous active-low reset
req_valid  in  1  decoded request valid
req_ready  out  1  request accepted when valid&ready
req_write  in  1  1 = posted write, 0 = non-posted read
req_addr  in  ADDR_W  byte address in BAR0
req_data  in  32  write data
req_tag  in  TAG_W  read tag
avm_address  out  ADDR_W  dword-aligned byte address
avm_read  out  1  Avalon read
avm_write  out  1  Avalon write
avm_writedata  out  32  write data
avm_waitrequest  in  1  Avalon stall
avm_readdata  in  32  read data
avm_readdatavalid  in  1  read data valid
cpl_valid  out  1  completion valid
cpl_ready  in  1  completion accepted
cpl_tag  out  TAG_W  completion tag
cpl_data  out  32  completion payload
cpl_err_ur_p  out  1  1-cycle UR pulse, posted
cpl_err_ur_np  out  1  1-cycle UR pulse, non-posted
pending  out  6  reads in flight plus buffered completions

Behaviour:
- Reset (async, reset_n=0): all outputs 0. Tag FIFO, completion FIFO, pending and credit counters are cleared. Reset mid-transaction discards in-flight reads, and any late avm_readdatavalid is ignored until the first request after reset.
- Misaligned access (req_addr[1:0]≠0):
  - Accepted in the same cycle (req_ready=1) and never issued to the bus.
  - Next cycle: cpl_err_ur_p=1 for a write, cpl_err_ur_np=1 for a read.
  - No completion is generated.
- Credit: a read is accepted only when pending < MAX_PENDING. Writes need no credit. Requests are strictly in order: a blocked read also blocks writes behind it.
- Issue stage: one registered command slot.
  - req_ready = slot empty or slot draining (!avm_waitrequest), AND the credit check passes for reads.
  - Command held stable while avm_waitrequest=1.
  - Accepted-to-avm_read/avm_write latency: 1 cycle.
- Issued read: its tag is pushed to the tag FIFO (depth MAX_PENDING) and pending increments.
- avm_readdatavalid: pops the tag FIFO and pushes {tag, data} to the completion FIFO (depth MAX_PENDING). The credit rule guarantees this FIFO never overflows.
- Completion output: cpl_valid = completion FIFO not empty, show-ahead. cpl_ready&cpl_valid pops the FIFO and decrements pending.
- Same-cycle accept of a read and completion pop: pending is unchanged.
- readdatavalid with an empty tag FIFO: ignored. Fatal assertion in simulation.
- pending saturates at MAX_PENDING. At MAX_PENDING, reads stall and the write path stays blocked behind them.

Optional Feature:
FEJKON_PCIE_TAG_CHECK_EN:
- Defined: a 2^TAG_W in-use bitmap is set on read accept and cleared on completion pop.
  - A read whose tag is already in use is accepted, dropped, and pulses cpl_err_ur_np.
  - Same-cycle pop and re-use of the same tag is legal.
- Undefined: no bitmap; duplicate tags pass through unchecked.

Decomposition:
- fejkon_pcie_pkg holds:
  - typedef bar_req_t {write, addr, data, tag}
  - typedef bar_cpl_t {tag, data}
  - constants PCIE_TAG_W=5, BAR0_ADDR_W=12
- One sub-module, fejkon_sync_fifo: parameterised width/depth, show-ahead, full/empty/count. It is instantiated twice (tag FIFO, completion FIFO).

Test Plan:
1. Write addr 14, data 0x1337 → no avm_write; cpl_err_ur_p pulses 1 cycle; cpl_err_ur_np stays 0. Read addr 14 → cpl_err_ur_np pulses; no avm_read.
2. 31 writes addr=i*4, data=i*4, then 31 reads tags 0..30 with cpl_ready=1 and 3-cycle read latency → 31 completions in order, tag i, data i*4; pending returns to 0.
3. cpl_ready=0, 33 back-to-back reads → exactly 32 accepted; req_ready=0 on the 33rd; pending=32. Raise cpl_ready → 33rd accepted one cycle after the first pop.
4. avm_waitrequest held 5 cycles on a write 0xdeadbeef to addr 512 → avm_write/address/data stable all 5 cycles; following read to 512 returns 0xdeadbeef.
5. reset_n low for 1 cycle with 4 reads in flight → all outputs 0 asynchronously; cpl_valid=0 after release; subsequent read tag 7 completes normally.
6. With FEJKON_PCIE_TAG_CHECK_EN: two reads tag 3 without a pop → second dropped, cpl_err_ur_np pulses, one completion. Without the macro → two completions with tag 3.
